// File: rtl/button_encoder_generic.sv
// Button front end: per-bit 2-flop synchronizer and debounce for active-low
// buttons, press-edge detection, priority encoding and a one-entry
// valid/ready output buffer with a sticky overrun flag.
module button_encoder_generic #(
    parameter int N         = 3,
    parameter int DB_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [0:2**N-1] btn_n,
    input  logic            ready,
    output logic [N-1:0]    code,
    output logic            valid,
    output logic            overrun,
    output logic            any_pressed
);

    localparam int NB = 2**N;
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [0:NB-1] sync1;
    logic [0:NB-1] sync2;
    logic [0:NB-1] raw;
    logic [0:NB-1] stable;
    logic [0:NB-1] stable_d;
    logic [0:NB-1] press;
    logic [CW-1:0] cnt [NB];
    logic [N-1:0]  win;
    logic          hit;
    logic          multi;

    assign raw   = ~sync2;
    assign press = stable & ~stable_d & {NB{en}};

    // Two-flop synchronizer per button; resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: toggle stable after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable   <= '0;
            stable_d <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int unsigned i = 0; i < NB; i++) begin
                if (raw[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Priority encode press edges: lowest index wins, flag simultaneous losers.
    always_comb begin
        win   = '0;
        hit   = 1'b0;
        multi = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (press[i]) begin
                if (hit) begin
                    multi = 1'b1;
                end else begin
                    win = N'(i);
                    hit = 1'b1;
                end
            end
        end
    end

    // One-entry output buffer with sticky overrun and registered any_pressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            code        <= '0;
            valid       <= 1'b0;
            overrun     <= 1'b0;
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |stable;
            if (hit) begin
                if (!valid || ready) begin
                    code  <= win;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
                if (multi) begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_encoder_generic.sv
// Bench for button_encoder_generic with N=2, DB_CYCLES=4: table of single
// press scenarios plus hand sequences for backpressure, enable and reset.
module tb_button_encoder_generic;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic            ready;
    logic [0:NB-1]   btn_n;
    logic [N-1:0]    code;
    logic            valid;
    logic            overrun;
    logic            any_pressed;

    int checks = 0;
    int errors = 0;
    int unsigned exp_q[$];
    int cyc;
    int first_valid;
    int nvalid;

    typedef struct {
        logic [NB-1:0] mask;     // bit i set = button i held low
        int            hold;     // edges the buttons stay low
        bit            en_v;
        int            exp_first;
        int            exp_code;
        int            exp_ovr;
        int            exp_ap_rise;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    button_encoder_generic #(.N(N), .DB_CYCLES(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .btn_n       (btn_n),
        .ready       (ready),
        .code        (code),
        .valid       (valid),
        .overrun     (overrun),
        .any_pressed (any_pressed)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: scoreboard the handshake seen before the edge, then sample.
    task automatic step();
        if (valid && ready) begin
            check("sb_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                int unsigned e;
                e = exp_q.pop_front();
                check("sb_code", int'(code), int'(e));
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (valid && first_valid < 0) first_valid = cyc;
        if (valid) nvalid++;
    endtask

    task automatic do_reset();
        btn_n = '1;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic clear_stats();
        cyc         = 0;
        first_valid = -1;
        nvalid      = 0;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        ready = 1'b0;
        btn_n = '1;
        clear_stats();

        vecs[0] = '{4'b0100, 12, 1'b1,  7, 2, 0,  7};
        vecs[1] = '{4'b0010,  3, 1'b1, -1, 0, 0, -1};
        vecs[2] = '{4'b1010, 12, 1'b1,  7, 1, 1,  7};
        vecs[3] = '{4'b0001, 12, 1'b1,  7, 0, 0,  7};
        vecs[4] = '{4'b1000, 12, 1'b0, -1, 0, 0,  7};
        vecs[5] = '{4'b1111, 12, 1'b1,  7, 0, 1,  7};
        vecs[6] = '{4'b1000,  4, 1'b1,  7, 3, 0,  7};
        vecs[7] = '{4'b1000,  3, 1'b1, -1, 0, 0, -1};

        do_reset();
        check("rst_valid", int'(valid), 0);
        check("rst_code", int'(code), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_any", int'(any_pressed), 0);

        // Table-driven single press scenarios with ready held high.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            en    = vecs[v].en_v;
            ready = 1'b1;
            if (vecs[v].exp_first >= 0) exp_q.push_back(vecs[v].exp_code);
            clear_stats();
            for (int i = 0; i < NB; i++) btn_n[i] = ~vecs[v].mask[i];
            for (int c = 1; c <= 24; c++) begin
                step();
                if (c == vecs[v].hold) btn_n = '1;
                if (vecs[v].exp_ap_rise >= 0) begin
                    if (c == vecs[v].exp_ap_rise - 1) check($sformatf("v%0d_ap_before", v), int'(any_pressed), 0);
                    if (c == vecs[v].exp_ap_rise)     check($sformatf("v%0d_ap_rise", v), int'(any_pressed), 1);
                    if (c == vecs[v].hold + 6)        check($sformatf("v%0d_ap_held", v), int'(any_pressed), 1);
                    if (c == vecs[v].hold + 7)        check($sformatf("v%0d_ap_fall", v), int'(any_pressed), 0);
                end else if (any_pressed) begin
                    check($sformatf("v%0d_ap_never", v), int'(any_pressed), 0);
                end
            end
            check($sformatf("v%0d_first", v), first_valid, vecs[v].exp_first);
            check($sformatf("v%0d_nvalid", v), nvalid, (vecs[v].exp_first >= 0) ? 1 : 0);
            check($sformatf("v%0d_overrun", v), int'(overrun), vecs[v].exp_ovr);
            check($sformatf("v%0d_sb_empty", v), exp_q.size(), 0);
        end

        // Backpressure: second press while valid && !ready is dropped.
        do_reset();
        en = 1'b1;
        ready = 1'b0;
        clear_stats();
        btn_n[0] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 10) btn_n[2] = 1'b0;
            if (c == 7)  check("bp_first_valid", int'(valid), 1);
            if (c == 16) check("bp_ovr_before", int'(overrun), 0);
            if (c == 17) check("bp_ovr_after", int'(overrun), 1);
        end
        check("bp_valid_held", int'(valid), 1);
        check("bp_code_held", int'(code), 0);
        exp_q.push_back(0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("bp_valid_drop", int'(valid), 0);
        check("bp_code_keep", int'(code), 0);
        nvalid = 0;
        for (int c = 0; c < 10; c++) step();
        check("bp_no_btn2", nvalid, 0);
        check("bp_sb_empty", exp_q.size(), 0);
        btn_n = '1;
        for (int c = 0; c < 10; c++) step();

        // Enable low during the press edge, then raised while still held.
        do_reset();
        en = 1'b0;
        ready = 1'b1;
        clear_stats();
        btn_n[3] = 1'b0;
        for (int c = 0; c < 12; c++) step();
        check("en0_nvalid", nvalid, 0);
        check("en0_any", int'(any_pressed), 1);
        en = 1'b1;
        for (int c = 0; c < 10; c++) step();
        check("en1_nvalid", nvalid, 0);
        btn_n = '1;
        for (int c = 0; c < 10; c++) step();

        // Reset while an event is pending and buttons are held.
        do_reset();
        en = 1'b1;
        ready = 1'b0;
        clear_stats();
        btn_n[0] = 1'b0;
        btn_n[1] = 1'b0;
        for (int c = 0; c < 8; c++) step();
        check("rm_valid_pre", int'(valid), 1);
        check("rm_ovr_pre", int'(overrun), 1);
        reset = 1'b1;
        step();
        check("rm_valid", int'(valid), 0);
        check("rm_code", int'(code), 0);
        check("rm_overrun", int'(overrun), 0);
        check("rm_any", int'(any_pressed), 0);
        step();
        reset = 1'b0;
        ready = 1'b1;
        exp_q.push_back(0);
        clear_stats();
        for (int c = 0; c < 10; c++) step();
        check("rm_first", first_valid, 7);
        check("rm_sb_empty", exp_q.size(), 0);
        btn_n = '1;
        for (int c = 0; c < 10; c++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
